// File: rtl/adc_sample_capture_if.sv
// adc_sample_capture_if: valid/ready sample stream from the capture block
// to the downstream test/analysis logic.
interface adc_sample_capture_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/adc_sample_capture.sv
// adc_sample_capture: detects adc_clk rising edges in the clk_in domain, captures
// adc_data into a show-ahead FIFO and streams it out on a valid/ready interface.
// Optional build macro: ADC_AVG_EN -- average consecutive raw sample pairs
// before pushing (odd final sample is pushed unaveraged).
module adc_sample_capture #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic                        adc_clk,
    input  logic [DATA_W-1:0]           adc_data,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_samples,
    input  logic                        abort,
    adc_sample_capture_if.master        m_if,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [CNT_W-1:0]            sample_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                adc_clk_d_r;
    logic [CNT_W-1:0]    target_r;
    logic [CNT_W-1:0]    count_r;
    logic                overflow_r;
    logic                done_r;
    logic                busy_r;
    logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;

    logic                rise_s;
    logic                empty_s;
    logic                full_s;
    logic                pop_s;
    logic                push_req_s;
    logic                push_s;
    logic                drop_s;
    logic [DATA_W-1:0]   push_data_s;
    logic [CNT_W:0]      count_inc_s;
    logic                at_target_s;
    logic                take_start_s;
    logic                zero_done_s;
    logic                finish_s;
    logic                sample_s;

    assign rise_s      = adc_clk & ~adc_clk_d_r;
    assign empty_s     = (level_r == {LVL_W{1'b0}});
    assign full_s      = (level_r == LVL_FULL);
    assign pop_s       = ~empty_s & m_if.m_ready;
    assign push_s      = push_req_s & (~full_s | pop_s);
    assign drop_s      = push_req_s & full_s & ~pop_s;
    assign count_inc_s = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};
    assign at_target_s = (count_inc_s == {1'b0, target_r});

    // Next-state and per-cycle control decode for the capture FSM; abort wins.
    always_comb begin
        state_next_s = state_r;
        take_start_s = 1'b0;
        zero_done_s  = 1'b0;
        finish_s     = 1'b0;
        sample_s     = 1'b0;
        if (abort) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (num_samples != {CNT_W{1'b0}}) begin
                            state_next_s = CAPTURE;
                            take_start_s = 1'b1;
                        end else begin
                            zero_done_s  = 1'b1;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CAPTURE: begin
                    if (rise_s) begin
                        sample_s = 1'b1;
                        if (at_target_s) begin
                            state_next_s = DRAIN;
                        end else begin
                            state_next_s = CAPTURE;
                        end
                    end else begin
                        state_next_s = CAPTURE;
                    end
                end
                DRAIN: begin
                    if (empty_s) begin
                        state_next_s = IDLE;
                        finish_s     = 1'b1;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

`ifdef ADC_AVG_EN
    logic              pair_valid_r;
    logic [DATA_W-1:0] pair_r;
    logic [DATA_W:0]   sum_s;

    assign sum_s = {1'b0, pair_r} + {1'b0, adc_data};

    // Push decode: one averaged push per pair; a lone final sample goes out as-is.
    always_comb begin
        push_req_s = sample_s & (pair_valid_r | at_target_s);
        if (pair_valid_r) begin
            push_data_s = sum_s[DATA_W:1];
        end else begin
            push_data_s = adc_data;
        end
    end

    // Pair register: holds the first sample of a pair, cleared on start and abort.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pair_valid_r <= 1'b0;
            pair_r       <= {DATA_W{1'b0}};
        end else if (abort || take_start_s) begin
            pair_valid_r <= 1'b0;
            pair_r       <= {DATA_W{1'b0}};
        end else if (sample_s) begin
            if (pair_valid_r || at_target_s) begin
                pair_valid_r <= 1'b0;
            end else begin
                pair_valid_r <= 1'b1;
                pair_r       <= adc_data;
            end
        end
    end
`else
    // Push decode: every accepted raw sample is pushed directly.
    always_comb begin
        push_req_s  = sample_s;
        push_data_s = adc_data;
    end
`endif

    // Control registers: edge-detect history, FSM state, counters and status flags.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            adc_clk_d_r <= 1'b0;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            target_r    <= {CNT_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            adc_clk_d_r <= adc_clk;
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != IDLE);
            done_r      <= zero_done_s | finish_s;
            if (take_start_s) begin
                target_r   <= num_samples;
                count_r    <= {CNT_W{1'b0}};
                overflow_r <= 1'b0;
            end else begin
                if (sample_s && (count_r != {CNT_W{1'b1}})) begin
                    count_r <= count_inc_s[CNT_W-1:0];
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // Show-ahead FIFO storage and pointers; abort flushes the contents.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (abort) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    assign m_if.m_data   = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
    assign m_if.m_valid  = ~empty_s;
    assign busy          = busy_r;
    assign done          = done_r;
    assign overflow      = overflow_r;
    assign sample_count  = count_r;
    assign fifo_level    = level_r;
endmodule

// File: tb/tb_adc_sample_capture.sv
// tb_adc_sample_capture: randomized and directed stimulus checked cycle by cycle
// against a queue-based reference model of the capture behaviour.
module tb_adc_sample_capture;
    localparam int DATA_W     = 12;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic              adc_clk;
    logic [DATA_W-1:0] adc_data;
    logic              start;
    logic [CNT_W-1:0]  num_samples;
    logic              abort;
    logic              ready;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  sample_count;
    logic [LVL_W-1:0]  fifo_level;

    adc_sample_capture_if #(.DATA_W(DATA_W)) m_if ();
    assign m_if.m_ready = ready;

    adc_sample_capture #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .adc_clk(adc_clk), .adc_data(adc_data),
        .start(start), .num_samples(num_samples), .abort(abort), .m_if(m_if),
        .busy(busy), .done(done), .overflow(overflow),
        .sample_count(sample_count), .fifo_level(fifo_level)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state: FIFO contents as a queue plus capture bookkeeping.
    int q[$];
    int data_list[$];
    bit mb_busy, mb_cap, mb_done, mb_ovf, mb_prev, mb_pair_have;
    int mb_target, mb_cnt, mb_pair;
    int checks = 0;
    int errors = 0;
    int hp = 5;
    int ph = 0;
    bit rand_ready = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mb_busy = 0; mb_cap = 0; mb_done = 0; mb_ovf = 0; mb_prev = 0;
        mb_pair_have = 0; mb_target = 0; mb_cnt = 0; mb_pair = 0;
    endtask

    // Apply the behavioural rules for one clk_in cycle using the current inputs.
    task automatic model_step();
        bit rise, pop, full, do_push;
        int sz, w, d;
        rise    = adc_clk && !mb_prev;
        mb_prev = adc_clk;
        sz      = q.size();
        pop     = (sz > 0) && ready;
        full    = (sz == FIFO_DEPTH);
        d       = int'(adc_data);
        mb_done = 0;
        do_push = 0;
        w       = 0;
        if (abort) begin
            q.delete();
            mb_busy = 0; mb_cap = 0; mb_pair_have = 0;
        end else begin
            if (!mb_busy) begin
                if (start) begin
                    if (num_samples != 0) begin
                        mb_busy = 1; mb_cap = 1; mb_target = int'(num_samples);
                        mb_cnt = 0; mb_ovf = 0; mb_pair_have = 0;
                    end else begin
                        mb_done = 1;
                    end
                end
            end else if (mb_cap) begin
                if (rise) begin
                    if (mb_cnt < 65535) mb_cnt++;
`ifdef ADC_AVG_EN
                    if (mb_pair_have) begin
                        do_push = 1; w = (mb_pair + d) / 2; mb_pair_have = 0;
                    end else if (mb_cnt == mb_target) begin
                        do_push = 1; w = d;
                    end else begin
                        mb_pair_have = 1; mb_pair = d;
                    end
`else
                    do_push = 1; w = d;
`endif
                    if (do_push && full && !pop) mb_ovf = 1;
                    if (mb_cnt == mb_target) mb_cap = 0;
                end
            end else if (sz == 0) begin
                mb_done = 1; mb_busy = 0;
            end
            if (pop) void'(q.pop_front());
            if (do_push && !(full && !pop)) q.push_back(w);
        end
    endtask

    task automatic check_outputs();
        check_value("m_valid", m_if.m_valid, (q.size() > 0));
        if (q.size() > 0) check_value("m_data", m_if.m_data, q[0]);
        check_value("fifo_level", fifo_level, q.size());
        check_value("busy", busy, mb_busy);
        check_value("done", done, mb_done);
        check_value("overflow", overflow, mb_ovf);
        check_value("sample_count", sample_count, mb_cnt);
    endtask

    // One clk_in cycle: model update, edge, check on the falling edge, then move adc_clk.
    task automatic step();
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
        check_outputs();
        ph++;
        if (ph >= hp) begin
            ph = 0;
            adc_clk = ~adc_clk;
            if (adc_clk) begin
                if (data_list.size() > 0) adc_data = DATA_W'(data_list.pop_front());
                else adc_data = DATA_W'($urandom);
            end
        end
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_adc(input int half);
        hp = half; ph = 0; adc_clk = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1; num_samples = CNT_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((busy || mb_busy) && n < budget) begin
            step(); n++;
        end
        if (n >= budget) check_value("idle_timeout", {30'd0, busy, mb_busy}, 32'd0);
        step(); step();
    endtask

    task automatic run_until_count(input int c, input int budget);
        int n = 0;
        while (mb_cnt < c && n < budget) begin
            step(); n++;
        end
        if (n >= budget) check_value("count_timeout", sample_count, c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; adc_clk = 1'b0; adc_data = '0; start = 1'b0;
        num_samples = '0; abort = 1'b0; ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_value("reset_m_valid", m_if.m_valid, 32'd0);
        check_value("reset_m_data", m_if.m_data, 32'd0);
        check_value("reset_busy", busy, 32'd0);
        rst_n = 1'b1;
        step(); step();

        // Basic 4-sample capture with ready high.
        set_adc(5); ready = 1'b1;
        data_list = '{32'h100, 32'h101, 32'h102, 32'h103};
        pulse_start(4);
        run_until_idle(300);
        check_value("t1_count", sample_count, 32'd4);
        check_value("t1_overflow", overflow, 32'd0);

        // Overflow with downstream stalled, then drain.
        set_adc(5); ready = 1'b0;
        pulse_start(10);
        run_until_count(10, 300);
        check_value("t2_level_full", fifo_level, FIFO_DEPTH);
        check_value("t2_overflow", overflow, 32'd1);
        ready = 1'b1;
        run_until_idle(300);
        check_value("t2_count", sample_count, 32'd10);

        // Abort after the second rise.
        set_adc(5); ready = 1'b0;
        pulse_start(6);
        run_until_count(2, 300);
        abort = 1'b1; step(); abort = 1'b0;
        check_value("t3_level", fifo_level, 32'd0);
        check_value("t3_busy", busy, 32'd0);
        check_value("t3_count", sample_count, 32'd2);
        repeat (4) step();

        // Zero-length request, then a start ignored during capture.
        ready = 1'b1;
        pulse_start(0);
        step(); step();
        set_adc(3);
        pulse_start(5);
        run_until_count(2, 300);
        pulse_start(1);
        run_until_idle(300);
        check_value("t4_count", sample_count, 32'd5);

        // Pair averaging data pattern (raw pushes in the default build).
        set_adc(4); ready = 1'b1;
        data_list = '{32'd10, 32'd13, 32'd7};
        pulse_start(3);
        run_until_idle(300);

        // Asynchronous reset mid-capture with three words queued.
        set_adc(2); ready = 1'b0;
        pulse_start(8);
        begin
            int n = 0;
            while (q.size() < 3 && n < 200) begin step(); n++; end
            if (n >= 200) check_value("t5_fill_timeout", fifo_level, 32'd3);
        end
        #2 rst_n = 1'b0;
        #1;
        check_value("t5_level", fifo_level, 32'd0);
        check_value("t5_valid", m_if.m_valid, 32'd0);
        check_value("t5_data", m_if.m_data, 32'd0);
        check_value("t5_busy", busy, 32'd0);
        check_value("t5_count", sample_count, 32'd0);
        check_value("t5_done", done, 32'd0);
        check_value("t5_overflow", overflow, 32'd0);
        model_reset();
        @(negedge clk_in);
        rst_n = 1'b1;
        set_adc(5);
        step(); step();

        // Randomized captures with random ready, aborts and stray starts.
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int n;
            set_adc($urandom_range(1, 4));
            pulse_start($urandom_range(0, 12));
            n = 0;
            while ((busy || mb_busy) && n < 600) begin
                if ($urandom_range(0, 79) == 0) abort = 1'b1;
                if ($urandom_range(0, 49) == 0) begin
                    start = 1'b1; num_samples = CNT_W'($urandom_range(0, 12));
                end
                step();
                abort = 1'b0; start = 1'b0;
                n++;
            end
            if (n >= 600) check_value("rand_timeout", {30'd0, busy, mb_busy}, 32'd0);
            step(); step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
